spi_slave_uart_bridge: RTL and testbench

SPI-slave-to-UART bridge: an external SPI master (mode 0, MSB first) clocks bytes into this block, which forwards each byte to the UART transmitter. Bytes arriving from the UART receiver are returned to the master on MISO during later SPI transfers. The block sits between the board SPI header pins and the existing `uart_rx`/`uart_tx` modules. It is the slave-side counterpart of the UART-to-SPI master bridge.

---
 rtl/spi_slave_uart_bridge.sv | 254 +++++++++++++++++++++++++
 tb/tb_spi_slave_uart_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_uart_bridge.sv
// SPI-slave (mode 0, MSB first) to UART bridge.
// Bytes clocked in on MOSI are queued to uart_tx; bytes from uart_rx are
// queued and shifted back out on MISO during later SPI transfers.
// Optional feature macro: SPI_UART_BRIDGE_DROP_CNT_EN enables the
// saturating drop counter; without it drop_cnt is tied to zero.
module spi_slave_uart_bridge #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       uart_rx_rdy,
  input  logic [7:0] uart_rx_data,
  output logic       uart_rx_rdy_clr,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_busy,
  output logic [7:0] drop_cnt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_BUSY = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_t;

  // Pin synchronisers: [0] first flop, [1] synchronised value, [2] edge history
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  // SPI shift state; sr_in holds the first 7 bits, the 8th completes the byte directly
  logic [2:0] bitcnt;
  logic [6:0] sr_in;
  logic [7:0] sr_out;

  // SPI->UART FIFO
  logic [7:0]       s2u_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] s2u_wr;
  logic [PTR_W-1:0] s2u_rd;
  logic [CNT_W-1:0] s2u_cnt;

  // UART->SPI FIFO
  logic [7:0]       u2s_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] u2s_wr;
  logic [PTR_W-1:0] u2s_rd;
  logic [CNT_W-1:0] u2s_cnt;

  tx_state_t tx_state;

  // Combinational control
  logic       sclk_rise_c;
  logic       sclk_fall_c;
  logic       cs_fall_c;
  logic       cs_rise_c;
  logic       cs_low_c;
  logic [2:0] bit_base_c;
  logic       rise_act_c;
  logic       byte_done_c;
  logic [7:0] rx_byte_c;
  logic       load_c;
  logic [7:0] sr_out_nxt_c;
  logic       s2u_full_c;
  logic       s2u_empty_c;
  logic       u2s_full_c;
  logic       u2s_empty_c;
  logic       s2u_push_c;
  logic       s2u_pop_c;
  logic       u2s_push_c;
  logic       u2s_pop_c;

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= 3'b111;
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SCLK};
      cs_sync   <= {cs_sync[1:0], CS};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign sclk_rise_c = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall_c = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall_c   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise_c   = cs_sync[1] & ~cs_sync[2];
  assign cs_low_c    = ~cs_sync[1];

  assign s2u_full_c  = (s2u_cnt == FULL_CNT);
  assign s2u_empty_c = (s2u_cnt == CNT_W'(0));
  assign u2s_full_c  = (u2s_cnt == FULL_CNT);
  assign u2s_empty_c = (u2s_cnt == CNT_W'(0));

  // SPI event decode; a CS fall restarts the byte before a coincident SCLK rise
  always_comb begin
    bit_base_c   = cs_fall_c ? 3'd0 : bitcnt;
    rise_act_c   = sclk_rise_c & cs_low_c;
    byte_done_c  = rise_act_c && (bit_base_c == 3'd7);
    rx_byte_c    = {sr_in, mosi_sync[1]};
    load_c       = cs_fall_c | byte_done_c;
    u2s_pop_c    = load_c & ~u2s_empty_c;
    s2u_push_c   = byte_done_c & ~s2u_full_c;
    u2s_push_c   = uart_rx_rdy & ~u2s_full_c & ~uart_rx_rdy_clr;
    sr_out_nxt_c = sr_out;
    if (load_c) begin
      sr_out_nxt_c = u2s_empty_c ? IDLE_BYTE : u2s_mem[u2s_rd];
    end else if (sclk_fall_c && cs_low_c && (bitcnt != 3'd0)) begin
      sr_out_nxt_c = {sr_out[6:0], 1'b0};
    end
  end

  // SPI bit counter, shift registers and registered MISO
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt <= 3'd0;
      sr_in  <= 7'h00;
      sr_out <= IDLE_BYTE;
      MISO   <= 1'b1;
    end else begin
      sr_out <= sr_out_nxt_c;
      MISO   <= cs_low_c ? sr_out_nxt_c[7] : 1'b1;
      if (cs_rise_c) begin
        bitcnt <= 3'd0;
      end else if (rise_act_c) begin
        sr_in  <= rx_byte_c[6:0];
        bitcnt <= bit_base_c + 3'd1;
      end else if (cs_fall_c) begin
        bitcnt <= 3'd0;
      end
    end
  end

  // SPI->UART FIFO storage
  always_ff @(posedge clk) begin
    if (s2u_push_c) begin
      s2u_mem[s2u_wr] <= rx_byte_c;
    end
  end

  // SPI->UART FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      s2u_wr  <= PTR_W'(0);
      s2u_rd  <= PTR_W'(0);
      s2u_cnt <= CNT_W'(0);
    end else begin
      if (s2u_push_c) begin
        s2u_wr <= s2u_wr + PTR_W'(1);
      end
      if (s2u_pop_c) begin
        s2u_rd <= s2u_rd + PTR_W'(1);
      end
      if (s2u_push_c && !s2u_pop_c) begin
        s2u_cnt <= s2u_cnt + CNT_W'(1);
      end else if (!s2u_push_c && s2u_pop_c) begin
        s2u_cnt <= s2u_cnt - CNT_W'(1);
      end
    end
  end

  // UART->SPI FIFO storage
  always_ff @(posedge clk) begin
    if (u2s_push_c) begin
      u2s_mem[u2s_wr] <= uart_rx_data;
    end
  end

  // UART->SPI FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      u2s_wr  <= PTR_W'(0);
      u2s_rd  <= PTR_W'(0);
      u2s_cnt <= CNT_W'(0);
    end else begin
      if (u2s_push_c) begin
        u2s_wr <= u2s_wr + PTR_W'(1);
      end
      if (u2s_pop_c) begin
        u2s_rd <= u2s_rd + PTR_W'(1);
      end
      if (u2s_push_c && !u2s_pop_c) begin
        u2s_cnt <= u2s_cnt + CNT_W'(1);
      end else if (!u2s_push_c && u2s_pop_c) begin
        u2s_cnt <= u2s_cnt - CNT_W'(1);
      end
    end
  end

  // Acknowledge accepted uart_rx bytes; the gap cycle keeps one rdy from pushing twice
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_rx_rdy_clr <= 1'b0;
    end else begin
      uart_rx_rdy_clr <= u2s_push_c;
    end
  end

  assign s2u_pop_c = (tx_state == TX_IDLE) && !s2u_empty_c && !uart_tx_busy;

  // UART TX handshake: start, wait for busy to rise, then wait for it to fall
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state      <= TX_IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      uart_tx_start <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (s2u_pop_c) begin
            uart_tx_data  <= s2u_mem[s2u_rd];
            uart_tx_start <= 1'b1;
            tx_state      <= TX_WAIT_BUSY;
          end
        end
        TX_WAIT_BUSY: begin
          if (uart_tx_busy) begin
            tx_state <= TX_WAIT_DONE;
          end
        end
        TX_WAIT_DONE: begin
          if (!uart_tx_busy) begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

`ifdef SPI_UART_BRIDGE_DROP_CNT_EN
  // Saturating count of completed SPI bytes refused by a full SPI->UART FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 8'h00;
    end else if (byte_done_c && s2u_full_c && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_slave_uart_bridge.sv
// Self-checking bench for spi_slave_uart_bridge: a bus-level SPI master,
// uart_rx/uart_tx models and a queue-based reference of both byte paths.
module tb_spi_slave_uart_bridge;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [7:0]  IDLE_BYTE  = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic       uart_rx_rdy;
  logic [7:0] uart_rx_data;
  logic       uart_rx_rdy_clr;
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic [7:0] drop_cnt;

  logic tx_busy_m;
  logic busy_stuck;
  int   busy_len = 8;

  int total = 0;
  int bad   = 0;

  logic [7:0] u2s_model [$];
  logic [7:0] exp_tx [$];
  logic [7:0] got_tx [$];
  logic [7:0] fr_tx  [8];
  logic [7:0] fr_rx  [8];
  logic [7:0] fr_exp [8];
  int         start_cnt = 0;
  int         clr_cnt   = 0;
  logic [7:0] exp_drop  = 8'h00;

  assign uart_tx_busy = tx_busy_m | busy_stuck;

  always #5 clk = ~clk;

  spi_slave_uart_bridge #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .IDLE_BYTE (IDLE_BYTE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .SCLK           (SCLK),
    .CS             (CS),
    .MOSI           (MOSI),
    .MISO           (MISO),
    .uart_rx_rdy    (uart_rx_rdy),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_rdy_clr(uart_rx_rdy_clr),
    .uart_tx_start  (uart_tx_start),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_busy   (uart_tx_busy),
    .drop_cnt       (drop_cnt)
  );

  // uart_tx model: capture each start, then stay busy for busy_len cycles
  initial begin
    tx_busy_m = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (uart_tx_start === 1'b1) begin
        got_tx.push_back(uart_tx_data);
        start_cnt++;
        repeat (2) @(posedge clk);
        #1 tx_busy_m = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy_m = 1'b0;
      end
    end
  end

  // Count rdy_clr pulses
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (uart_rx_rdy_clr === 1'b1) clr_cnt++;
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference: each sr_out load takes the oldest queued UART byte, else IDLE_BYTE
  function automatic logic [7:0] model_load();
    if (u2s_model.size() > 0) return u2s_model.pop_front();
    return IDLE_BYTE;
  endfunction

  task automatic spi_bit(input logic b, output logic m);
    MOSI = b;
    repeat (5) @(negedge clk);
    m = MISO;
    SCLK = 1'b1;
    repeat (5) @(negedge clk);
    SCLK = 1'b0;
  endtask

  // One CS frame of n bytes; loads happen at CS fall and after every byte
  task automatic run_frame(input int n, input bit fwd);
    logic       m;
    logic [7:0] b;
    logic [7:0] nxt;
    CS = 1'b0;
    fr_exp[0] = model_load();
    repeat (6) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      b = fr_tx[k];
      for (int i = 7; i >= 0; i--) begin
        spi_bit(b[i], m);
        fr_rx[k][i] = m;
      end
      nxt = model_load();
      if (k + 1 < n) fr_exp[k+1] = nxt;
      if (fwd) exp_tx.push_back(b);
    end
    repeat (5) @(negedge clk);
    CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic uart_push(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    uart_rx_data = b;
    uart_rx_rdy  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (uart_rx_rdy_clr === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    uart_rx_rdy = 1'b0;
    if (ok) u2s_model.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_tx(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_tx.size() >= exp_tx.size()) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    uart_rx_rdy = 1'b0; uart_rx_data = 8'h00; busy_stuck = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL reset_miso got=%b exp=1", MISO); end
    total++; if (uart_rx_rdy_clr !== 1'b0) begin bad++; $display("FAIL reset_rdy_clr got=%b exp=0", uart_rx_rdy_clr); end
    total++; if (uart_tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b exp=0", uart_tx_start); end
    total++; if (uart_tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", uart_tx_data); end
    total++; if (drop_cnt !== 8'h00) begin bad++; $display("FAIL reset_drop_cnt got=%h exp=00", drop_cnt); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL post_reset_miso got=%b exp=1", MISO); end
  endtask

  task automatic test_single_byte();
    bit ok;
    int s0;
    s0 = start_cnt;
    fr_tx[0] = 8'hA5;
    run_frame(1, 1'b1);
    total++; if (fr_rx[0] !== fr_exp[0]) begin bad++; $display("FAIL single_miso got=%h exp=%h", fr_rx[0], fr_exp[0]); end
    wait_tx(500, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d bytes exp=%0d", got_tx.size(), exp_tx.size()); end
    total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL single_start_cnt got=%0d exp=1", start_cnt - s0); end
    total++; if (got_tx.size() < 1 || got_tx[0] !== 8'hA5) begin bad++; $display("FAIL single_tx_data got=%h exp=a5", (got_tx.size() > 0) ? got_tx[0] : 8'hxx); end
    got_tx.delete(); exp_tx.delete();
  endtask

  task automatic test_uart_to_miso();
    bit ok;
    int c0;
    c0 = clr_cnt;
    uart_push(8'h3C, ok);
    total++; if (!ok) begin bad++; $display("FAIL u2m_push_timeout got=0 exp=1"); end
    repeat (10) @(negedge clk);
    total++; if (clr_cnt - c0 != 1) begin bad++; $display("FAIL u2m_clr_pulses got=%0d exp=1", clr_cnt - c0); end
    fr_tx[0] = 8'($urandom);
    run_frame(1, 1'b1);
    total++; if (fr_rx[0] !== 8'h3C) begin bad++; $display("FAIL u2m_first_read got=%h exp=3c", fr_rx[0]); end
    fr_tx[0] = 8'($urandom);
    run_frame(1, 1'b1);
    total++; if (fr_rx[0] !== 8'hFF) begin bad++; $display("FAIL u2m_second_read got=%h exp=ff", fr_rx[0]); end
    wait_tx(500, ok);
    total++; if (!ok || got_tx.size() != exp_tx.size()) begin bad++; $display("FAIL u2m_tx_count got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++; if (got_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL u2m_tx_byte%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]); end
    end
    got_tx.delete(); exp_tx.delete();
  endtask

  task automatic test_burst();
    bit ok;
    busy_len = 2000;
    for (int k = 0; k < 4; k++) fr_tx[k] = 8'(k + 1);
    run_frame(4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      total++; if (fr_rx[k] !== fr_exp[k]) begin bad++; $display("FAIL burst_miso%0d got=%h exp=%h", k, fr_rx[k], fr_exp[k]); end
    end
    wait_tx(12000, ok);
    total++; if (!ok || got_tx.size() != 4) begin bad++; $display("FAIL burst_tx_count got=%0d exp=4", got_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++; if (got_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL burst_tx_byte%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]); end
    end
    total++; if (drop_cnt !== exp_drop) begin bad++; $display("FAIL burst_drop_cnt got=%h exp=%h", drop_cnt, exp_drop); end
    busy_len = 8;
    got_tx.delete(); exp_tx.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    busy_stuck = 1'b1;
    for (int k = 0; k < 6; k++) fr_tx[k] = 8'($urandom);
    run_frame(6, 1'b0);
    for (int k = 0; k < int'(FIFO_DEPTH); k++) exp_tx.push_back(fr_tx[k]);
`ifdef SPI_UART_BRIDGE_DROP_CNT_EN
    exp_drop = exp_drop + 8'd2;
`endif
    repeat (20) @(negedge clk);
    total++; if (got_tx.size() != 0) begin bad++; $display("FAIL ovf_sent_while_busy got=%0d exp=0", got_tx.size()); end
    total++; if (drop_cnt !== exp_drop) begin bad++; $display("FAIL ovf_drop_cnt got=%h exp=%h", drop_cnt, exp_drop); end
    busy_stuck = 1'b0;
    wait_tx(2000, ok);
    total++; if (!ok || got_tx.size() != exp_tx.size()) begin bad++; $display("FAIL ovf_tx_count got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++; if (got_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL ovf_tx_byte%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]); end
    end
    got_tx.delete(); exp_tx.delete();
  endtask

  task automatic test_abort();
    bit         ok;
    logic       m;
    logic [7:0] b;
    logic [7:0] ld;
    CS = 1'b0;
    ld = model_load();
    repeat (6) @(negedge clk);
    b = 8'hF0;
    for (int i = 7; i >= 3; i--) spi_bit(b[i], m);
    repeat (3) @(negedge clk);
    CS = 1'b1;
    repeat (60) @(negedge clk);
    total++; if (got_tx.size() != 0) begin bad++; $display("FAIL abort_no_push got=%0d exp=0", got_tx.size()); end
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL abort_miso_idle got=%b exp=1", MISO); end
    fr_tx[0] = 8'h81;
    run_frame(1, 1'b1);
    total++; if (fr_rx[0] !== fr_exp[0]) begin bad++; $display("FAIL abort_next_miso got=%h exp=%h (lost %h)", fr_rx[0], fr_exp[0], ld); end
    wait_tx(500, ok);
    total++; if (!ok || got_tx.size() != 1 || got_tx[0] !== 8'h81) begin bad++; $display("FAIL abort_next_tx got=%0d bytes first=%h exp=81", got_tx.size(), (got_tx.size() > 0) ? got_tx[0] : 8'hxx); end
    got_tx.delete(); exp_tx.delete();
  endtask

  task automatic test_mid_reset();
    bit         ok;
    logic       m;
    logic [7:0] b;
    uart_push(8'($urandom), ok);
    uart_push(8'($urandom), ok);
    total++; if (!ok) begin bad++; $display("FAIL mrst_push_timeout got=0 exp=1"); end
    CS = 1'b0;
    repeat (6) @(negedge clk);
    b = 8'($urandom);
    for (int i = 7; i >= 5; i--) spi_bit(b[i], m);
    rst = 1'b1; CS = 1'b1; SCLK = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL mrst_miso got=%b exp=1", MISO); end
    total++; if (uart_rx_rdy_clr !== 1'b0) begin bad++; $display("FAIL mrst_rdy_clr got=%b exp=0", uart_rx_rdy_clr); end
    total++; if (uart_tx_start !== 1'b0) begin bad++; $display("FAIL mrst_tx_start got=%b exp=0", uart_tx_start); end
    total++; if (uart_tx_data !== 8'h00) begin bad++; $display("FAIL mrst_tx_data got=%h exp=00", uart_tx_data); end
    total++; if (drop_cnt !== 8'h00) begin bad++; $display("FAIL mrst_drop_cnt got=%h exp=00", drop_cnt); end
    rst = 1'b0;
    u2s_model.delete(); got_tx.delete(); exp_tx.delete();
    exp_drop = 8'h00;
    repeat (5) @(negedge clk);
    fr_tx[0] = 8'h55;
    run_frame(1, 1'b1);
    total++; if (fr_rx[0] !== fr_exp[0]) begin bad++; $display("FAIL mrst_next_miso got=%h exp=%h", fr_rx[0], fr_exp[0]); end
    wait_tx(500, ok);
    total++; if (!ok || got_tx.size() != 1 || got_tx[0] !== 8'h55) begin bad++; $display("FAIL mrst_next_tx got=%0d bytes first=%h exp=55", got_tx.size(), (got_tx.size() > 0) ? got_tx[0] : 8'hxx); end
    got_tx.delete(); exp_tx.delete();
  endtask

  task automatic test_random();
    bit ok;
    int np;
    int n;
    for (int it = 0; it < 10; it++) begin
      busy_len = int'($urandom_range(5, 30));
      np = int'($urandom_range(0, 2));
      for (int p = 0; p < np; p++) begin
        uart_push(8'($urandom), ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_push_timeout it=%0d got=0 exp=1", it); end
      end
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) fr_tx[k] = 8'($urandom);
      run_frame(n, 1'b1);
      for (int k = 0; k < n; k++) begin
        total++; if (fr_rx[k] !== fr_exp[k]) begin bad++; $display("FAIL rnd_miso it=%0d byte=%0d got=%h exp=%h", it, k, fr_rx[k], fr_exp[k]); end
      end
    end
    wait_tx(4000, ok);
    total++; if (!ok || got_tx.size() != exp_tx.size()) begin bad++; $display("FAIL rnd_tx_count got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++; if (got_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL rnd_tx_byte%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]); end
    end
    total++; if (drop_cnt !== exp_drop) begin bad++; $display("FAIL rnd_drop_cnt got=%h exp=%h", drop_cnt, exp_drop); end
    got_tx.delete(); exp_tx.delete();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_uart_to_miso();
    test_burst();
    test_overflow();
    test_abort();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
